// File: rtl/bus_datapath_seq_if.sv
// rtl/bus_datapath_seq_if.sv - control-unit handshake bundle for bus_datapath_seq
// The control unit drives the instruction fields and start; the datapath answers with busy/done.
interface bus_datapath_seq_if #(
  parameter int REG_AW = 4
);
  logic              start;
  logic [2:0]        op;
  logic [REG_AW-1:0] ra;
  logic [REG_AW-1:0] rb;
  logic [REG_AW-1:0] rc;
  logic              busy;
  logic              done;

  modport master (output start, op, ra, rb, rc, input busy, done);
  modport slave  (input start, op, ra, rb, rc, output busy, done);
endinterface

// File: rtl/bus_datapath_seq.sv
// rtl/bus_datapath_seq.sv - single-bus datapath with a built-in T-state instruction sequencer
// One three-operand instruction per start: LDY (Y <= R[rb]), EXE (Z <= ALU), WB (R[ra] or HI/LO).
module bus_datapath_seq #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int REG_AW   = 4
) (
  input  logic                  clk,
  input  logic                  clr,
  bus_datapath_seq_if.slave     ctl,
  input  logic [DATA_W-1:0]     in_port,
  output logic [DATA_W-1:0]     bus_out,
  output logic [DATA_W-1:0]     hi_out,
  output logic [DATA_W-1:0]     lo_out,
  input  logic [REG_AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0]     dbg_data
);

  localparam int SH_W     = $clog2(DATA_W);
  localparam int RF_DEPTH = 1 << REG_AW;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_SHL = 3'd4;
  localparam logic [2:0] OP_SHR = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_LDI = 3'd7;

  localparam int SRC_RB  = 0;
  localparam int SRC_RC  = 1;
  localparam int SRC_ZLO = 2;
  localparam int SRC_INP = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LDY,
    S_EXE,
    S_WB,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            op_q;
  logic [REG_AW-1:0]     ra_q, rb_q, rc_q;
  logic [DATA_W-1:0]     regs_q [NUM_REGS];
  logic [DATA_W-1:0]     y_q;
  logic [2*DATA_W-1:0]   z_q;
  logic [DATA_W-1:0]     hi_q, lo_q;
  logic [DATA_W-1:0]     inport_q;

  logic [3:0]            src_sel;
  logic                  fields_ld;
  logic                  y_ld;
  logic                  z_ld;
  logic                  rf_wr;
  logic                  hilo_wr;
  logic                  busy_c;
  logic                  done_c;

  logic [DATA_W-1:0]     bus;
  logic [DATA_W-1:0]     rf_view [RF_DEPTH];
  logic [2*DATA_W-1:0]   alu_z;
  logic [2*DATA_W-1:0]   y_sx, b_sx;
  logic [SH_W-1:0]       shamt;

  // Addresses beyond NUM_REGS see a hard zero instead of an out-of-range array read.
  for (genvar g = 0; g < RF_DEPTH; g++) begin : g_view
    if (g < NUM_REGS) begin : g_reg
      assign rf_view[g] = regs_q[g];
    end else begin : g_zero
      assign rf_view[g] = '0;
    end
  end

  always_comb begin
    state_d   = state_q;
    src_sel   = '0;
    fields_ld = 1'b0;
    y_ld      = 1'b0;
    z_ld      = 1'b0;
    rf_wr     = 1'b0;
    hilo_wr   = 1'b0;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ctl.start) begin
          fields_ld = 1'b1;
          state_d   = S_LDY;
        end
      end
      S_LDY: begin
        busy_c          = 1'b1;
        src_sel[SRC_RB] = 1'b1;
        y_ld            = 1'b1;
        state_d         = S_EXE;
      end
      S_EXE: begin
        busy_c          = 1'b1;
        src_sel[SRC_RC] = 1'b1;
        z_ld            = 1'b1;
        state_d         = S_WB;
      end
      S_WB: begin
        busy_c = 1'b1;
        if (op_q == OP_LDI) begin
          src_sel[SRC_INP] = 1'b1;
          rf_wr            = 1'b1;
        end else if (op_q == OP_MUL) begin
          src_sel[SRC_ZLO] = 1'b1;
          hilo_wr          = 1'b1;
        end else begin
          src_sel[SRC_ZLO] = 1'b1;
          rf_wr            = 1'b1;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus = ({DATA_W{src_sel[SRC_RB]}}  & rf_view[rb_q])
             | ({DATA_W{src_sel[SRC_RC]}}  & rf_view[rc_q])
             | ({DATA_W{src_sel[SRC_ZLO]}} & z_q[DATA_W-1:0])
             | ({DATA_W{src_sel[SRC_INP]}} & inport_q);

  // Sign-extending both operands to 2*DATA_W makes the low half of an unsigned product the signed product.
  assign y_sx  = {{DATA_W{y_q[DATA_W-1]}}, y_q};
  assign b_sx  = {{DATA_W{bus[DATA_W-1]}}, bus};
  assign shamt = bus[SH_W-1:0];

  always_comb begin
    alu_z = '0;
    case (op_q)
      OP_ADD:  alu_z[DATA_W-1:0] = y_q + bus;
      OP_SUB:  alu_z[DATA_W-1:0] = y_q - bus;
      OP_AND:  alu_z[DATA_W-1:0] = y_q & bus;
      OP_OR:   alu_z[DATA_W-1:0] = y_q | bus;
      OP_SHL:  alu_z[DATA_W-1:0] = y_q << shamt;
      OP_SHR:  alu_z[DATA_W-1:0] = y_q >> shamt;
      OP_MUL:  alu_z = y_sx * b_sx;
      default: alu_z = '0;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rc_q     <= '0;
      y_q      <= '0;
      z_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      inport_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      inport_q <= in_port;
      if (fields_ld) begin
        op_q <= ctl.op;
        ra_q <= ctl.ra;
        rb_q <= ctl.rb;
        rc_q <= ctl.rc;
      end
      if (y_ld) y_q <= bus;
      if (z_ld) z_q <= alu_z;
      if (hilo_wr) begin
        hi_q <= z_q[2*DATA_W-1:DATA_W];
        lo_q <= z_q[DATA_W-1:0];
      end
      for (int i = 0; i < NUM_REGS; i++) begin
        if (rf_wr && (ra_q == REG_AW'(i))) regs_q[i] <= bus;
      end
    end
  end

  assign ctl.busy = busy_c;
  assign ctl.done = done_c;
  assign bus_out  = bus;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
  assign dbg_data = rf_view[dbg_addr];

endmodule

// File: tb/tb_bus_datapath_seq.sv
// tb/tb_bus_datapath_seq.sv - self-checking bench for bus_datapath_seq
module tb_bus_datapath_seq;
  localparam int W  = 32;
  localparam int AW = 4;
  localparam int NR = 16;

  logic          clk = 1'b0;
  logic          clr;
  logic [W-1:0]  in_port;
  logic [W-1:0]  bus_out, hi_out, lo_out, dbg_data;
  logic [AW-1:0] dbg_addr;

  bus_datapath_seq_if #(.REG_AW(AW)) ifc ();

  bus_datapath_seq #(.DATA_W(W), .NUM_REGS(NR), .REG_AW(AW)) dut (
    .clk      (clk),
    .clr      (clr),
    .ctl      (ifc.slave),
    .in_port  (in_port),
    .bus_out  (bus_out),
    .hi_out   (hi_out),
    .lo_out   (lo_out),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] m_r [NR];
  logic [W-1:0] m_hi, m_lo;

  typedef struct {
    logic [2:0]   op;
    logic [3:0]   ra, rb, rc;
    logic [W-1:0] a, b, er, ehi, elo;
  } vec_t;
  vec_t tv [10];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [3:0] a, output logic [W-1:0] d);
    dbg_addr = a;
    #1;
    d = dbg_data;
  endtask

  task automatic check_all(input string name);
    logic [W-1:0] d;
    for (int i = 0; i < NR; i++) begin
      rd(4'(i), d);
      chk(name, d, m_r[i]);
    end
  endtask

  function automatic logic [63:0] ref_z(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    case (op)
      3'd0: return {32'd0, a + b};
      3'd1: return {32'd0, a - b};
      3'd2: return {32'd0, a & b};
      3'd3: return {32'd0, a | b};
      3'd4: return {32'd0, a << (b % 32)};
      3'd5: return {32'd0, a >> (b % 32)};
      3'd6: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
      end
      default: return 64'd0;
    endcase
  endfunction

  // Issues one instruction from a negedge and follows it through every T-state.
  task automatic run(input logic [2:0] op, input logic [3:0] ra, input logic [3:0] rb,
                     input logic [3:0] rc, input logic [W-1:0] val);
    logic [63:0]  z;
    logic [W-1:0] d;
    z = ref_z(op, m_r[rb], m_r[rc]);
    in_port   = val;
    ifc.op    = op;
    ifc.ra    = ra;
    ifc.rb    = rb;
    ifc.rc    = rc;
    ifc.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifc.start = 1'b0;
    chk("ldy_busy", 32'(ifc.busy), 1);
    chk("ldy_bus", bus_out, m_r[rb]);
    @(negedge clk);
    chk("exe_bus", bus_out, m_r[rc]);
    @(negedge clk);
    chk("wb_busy", 32'(ifc.busy), 1);
    chk("wb_done", 32'(ifc.done), 0);
    chk("wb_bus", bus_out, (op == 3'd7) ? val : z[31:0]);
    @(negedge clk);
    if (op == 3'd6) begin
      m_hi = z[63:32];
      m_lo = z[31:0];
    end else if (op == 3'd7) begin
      m_r[ra] = val;
    end else begin
      m_r[ra] = z[31:0];
    end
    chk("done_pulse", 32'(ifc.done), 1);
    chk("done_busy", 32'(ifc.busy), 0);
    chk("done_bus", bus_out, 0);
    chk("hi", hi_out, m_hi);
    chk("lo", lo_out, m_lo);
    rd(ra, d);
    chk("rf_ra", d, m_r[ra]);
    @(negedge clk);
    chk("idle_done", 32'(ifc.done), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] d, exp15, old8;
    int           pulses;

    tv[0] = '{3'd0, 4'd3,  4'd1,  4'd2,  32'd5,        32'd7,        32'd12,       32'd0,        32'd0};
    tv[1] = '{3'd1, 4'd4,  4'd1,  4'd2,  32'd3,        32'd5,        32'hFFFFFFFE, 32'd0,        32'd0};
    tv[2] = '{3'd6, 4'd7,  4'd1,  4'd2,  32'hFFFFFFFF, 32'd2,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFE};
    tv[3] = '{3'd5, 4'd5,  4'd1,  4'd2,  32'h80000001, 32'h21,       32'h40000000, 32'd0,        32'd0};
    tv[4] = '{3'd2, 4'd6,  4'd8,  4'd9,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'd0,        32'd0};
    tv[5] = '{3'd3, 4'd10, 4'd8,  4'd9,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 32'd0,        32'd0};
    tv[6] = '{3'd4, 4'd11, 4'd12, 4'd13, 32'd1,        32'h3F,       32'h80000000, 32'd0,        32'd0};
    tv[7] = '{3'd0, 4'd14, 4'd12, 4'd13, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        32'd0};
    tv[8] = '{3'd0, 4'd1,  4'd1,  4'd2,  32'd10,       32'd20,       32'd30,       32'd0,        32'd0};
    tv[9] = '{3'd6, 4'd0,  4'd3,  4'd4,  32'd7,        32'hFFFFFFFD, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFEB};

    clr = 1'b0;
    in_port = '0;
    dbg_addr = '0;
    ifc.start = 1'b0;
    ifc.op = '0;
    ifc.ra = '0;
    ifc.rb = '0;
    ifc.rc = '0;
    for (int i = 0; i < NR; i++) m_r[i] = '0;
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(ifc.busy), 0);
    chk("rst_done", 32'(ifc.done), 0);
    chk("rst_bus", bus_out, 0);
    chk("rst_hi", hi_out, 0);
    chk("rst_lo", lo_out, 0);
    check_all("rst_rf");
    clr = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 10; t++) begin
      run(3'd7, tv[t].rb, 4'd0, 4'd0, tv[t].a);
      run(3'd7, tv[t].rc, 4'd0, 4'd0, tv[t].b);
      old8 = m_r[tv[t].ra];
      run(tv[t].op, tv[t].ra, tv[t].rb, tv[t].rc, 32'h0);
      if (tv[t].op == 3'd6) begin
        chk("tv_hi", hi_out, tv[t].ehi);
        chk("tv_lo", lo_out, tv[t].elo);
        rd(tv[t].ra, d);
        chk("tv_mul_ra_kept", d, old8);
        check_all("tv_mul_rf");
      end else begin
        rd(tv[t].ra, d);
        chk("tv_result", d, tv[t].er);
      end
    end

    // Stray start pulses in LDY and in DONE must neither queue nor retarget the write.
    exp15 = m_r[1] + m_r[2];
    old8  = m_r[8];
    in_port = '0;
    ifc.op = 3'd0;
    ifc.ra = 4'd15;
    ifc.rb = 4'd1;
    ifc.rc = 4'd2;
    ifc.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifc.op = 3'd7;
    ifc.ra = 4'd8;
    in_port = 32'hDEADBEEF;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 1) ifc.start = 1'b0;
      if (c == 3) ifc.start = 1'b1;
      if (c == 4) ifc.start = 1'b0;
      if (ifc.done) pulses++;
      @(negedge clk);
    end
    m_r[15] = exp15;
    chk("stray_pulses", pulses, 1);
    chk("stray_idle_busy", 32'(ifc.busy), 0);
    rd(4'd15, d);
    chk("stray_r15", d, exp15);
    rd(4'd8, d);
    chk("stray_r8", d, old8);

    // Reset dropped during EXE of ADD into R6.
    ifc.op = 3'd0;
    ifc.ra = 4'd6;
    ifc.rb = 4'd1;
    ifc.rc = 4'd2;
    ifc.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifc.start = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) m_r[i] = '0;
    m_hi = '0;
    m_lo = '0;
    chk("midrst_busy", 32'(ifc.busy), 0);
    chk("midrst_done", 32'(ifc.done), 0);
    chk("midrst_bus", bus_out, 0);
    chk("midrst_hi", hi_out, 0);
    rd(4'd6, d);
    chk("midrst_r6", d, 0);
    @(negedge clk);
    clr = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ifc.done) pulses++;
    end
    chk("midrst_no_done", pulses, 0);
    check_all("midrst_rf");
    run(3'd7, 4'd1, 4'd0, 4'd0, 32'd5);
    run(3'd7, 4'd2, 4'd0, 4'd0, 32'd7);
    run(3'd0, 4'd6, 4'd1, 4'd2, 32'd0);
    rd(4'd6, d);
    chk("post_rst_add", d, 32'd12);

    for (int n = 0; n < 40; n++) begin
      run(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
          4'($urandom_range(0, 15)), $urandom);
    end
    check_all("rand_rf");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
